// File: rtl/pipeline_perf_monitor_if.sv
// ----------------------------------------------------------------------------
// pipeline_perf_monitor_if
//   Bundles the control, event and readout signals of the performance
//   monitor so the CPU-side logic and the monitor share one connection.
//
//   Parameters
//     NUM_CH  number of event channels
//     CNT_W   counter width
//
//   Signals (direction seen from the monitor, i.e. the slave modport)
//     start_i       in   run enable
//     clear_i       in   synchronous clear of live counters
//     event_i       in   per-channel event strobes
//     snap_i        in   copy live counters into shadow registers
//     rd_sel_i      in   shadow channel select
//     rd_data_o     out  registered shadow[rd_sel_i]
//     cycle_o       out  live cycle counter
//     state_o       out  00 IDLE, 01 RUN, 10 DONE
//     done_o        out  high while in DONE
//     snap_valid_o  out  a snapshot has been taken since reset
//     ovf_o         out  sticky per-channel overflow flags
//                        (only with PERF_OVERFLOW_FLAGS_EN defined)
// ----------------------------------------------------------------------------
interface pipeline_perf_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              start_i;
  logic              clear_i;
  logic [NUM_CH-1:0] event_i;
  logic              snap_i;
  logic [SEL_W-1:0]  rd_sel_i;
  logic [CNT_W-1:0]  rd_data_o;
  logic [CNT_W-1:0]  cycle_o;
  logic [1:0]        state_o;
  logic              done_o;
  logic              snap_valid_o;
`ifdef PERF_OVERFLOW_FLAGS_EN
  logic [NUM_CH-1:0] ovf_o;

  modport master (
    output start_i, clear_i, event_i, snap_i, rd_sel_i,
    input  rd_data_o, cycle_o, state_o, done_o, snap_valid_o, ovf_o
  );

  modport slave (
    input  start_i, clear_i, event_i, snap_i, rd_sel_i,
    output rd_data_o, cycle_o, state_o, done_o, snap_valid_o, ovf_o
  );
`else
  modport master (
    output start_i, clear_i, event_i, snap_i, rd_sel_i,
    input  rd_data_o, cycle_o, state_o, done_o, snap_valid_o
  );

  modport slave (
    input  start_i, clear_i, event_i, snap_i, rd_sel_i,
    output rd_data_o, cycle_o, state_o, done_o, snap_valid_o
  );
`endif

endinterface

// File: rtl/pipeline_perf_monitor.sv
// ----------------------------------------------------------------------------
// pipeline_perf_monitor
//   Performance-counter block for the pipelined CPU. Counts RUN cycles and
//   NUM_CH qualified event strobes, stops after CYCLE_LIMIT cycles, and offers
//   an atomic snapshot of all channels into shadow registers that are read
//   back one channel at a time.
//
//   Parameters
//     NUM_CH       event channels (1..16)
//     CNT_W        width of every counter, cycle counter included
//     CYCLE_LIMIT  RUN cycles before DONE, 0 = unlimited
//     SATURATE     0 = wrap modulo 2^CNT_W, 1 = hold at all-ones
//
//   Ports
//     clk_i  clock, rising edge
//     rst_i  asynchronous active-low reset
//     bus    pipeline_perf_monitor_if.slave (control, events, readout)
//
//   Optional feature macro: PERF_OVERFLOW_FLAGS_EN
//     Adds sticky per-channel overflow flags on bus.ovf_o.
// ----------------------------------------------------------------------------
module pipeline_perf_monitor #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 70,
  parameter int SATURATE    = 0
) (
  input logic                    clk_i,
  input logic                    rst_i,
  pipeline_perf_monitor_if.slave bus
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // A limit that does not fit in CNT_W bits can never be reached, so it is
  // treated the same as "no limit" instead of being silently truncated.
  localparam bit LIMIT_ON = (CYCLE_LIMIT > 0) && ($clog2(CYCLE_LIMIT + 1) <= CNT_W);

  localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(CYCLE_LIMIT);
  localparam logic [CNT_W-1:0] ALL_ONES  = '1;
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] cnt    [NUM_CH];
  logic [CNT_W-1:0] shadow [NUM_CH];
  logic [CNT_W-1:0] rd_data;
  logic [CNT_W-1:0] rd_next;
  logic             done;
  logic             snap_valid;

  // Increment with the configured overflow policy.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    if ((SATURATE != 0) && (v == ALL_ONES))
      return v;
    return v + ONE;
  endfunction

`ifdef PERF_OVERFLOW_FLAGS_EN
  logic [NUM_CH-1:0] ovf;

  // True when incrementing v raises the overflow flag: the wrap from
  // all-ones in wrap mode, or the step onto all-ones in saturate mode.
  function automatic logic ovf_hit(input logic [CNT_W-1:0] v);
    if (SATURATE != 0)
      return v == (ALL_ONES - ONE);
    return v == ALL_ONES;
  endfunction
`endif

  // Read mux over the shadows; an out-of-range select falls through to 0.
  always_comb begin
    rd_next = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.rd_sel_i == SEL_W'(k))
        rd_next = shadow[k];
    end
  end

  // Control FSM, counters, shadows and readout register.
  // The snapshot and the read register sample values from before this edge,
  // which gives pre-increment / pre-clear snapshots and the one-cycle delay
  // before a freshly written shadow becomes visible on the read port.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      cycle_cnt  <= '0;
      rd_data    <= '0;
      done       <= 1'b0;
      snap_valid <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt[k]    <= '0;
        shadow[k] <= '0;
      end
`ifdef PERF_OVERFLOW_FLAGS_EN
      ovf <= '0;
`endif
    end else begin
      rd_data <= rd_next;

      if (bus.snap_i) begin
        for (int k = 0; k < NUM_CH; k++)
          shadow[k] <= cnt[k];
        snap_valid <= 1'b1;
      end

      if (bus.clear_i) begin
        state     <= ST_IDLE;
        done      <= 1'b0;
        cycle_cnt <= '0;
        for (int k = 0; k < NUM_CH; k++)
          cnt[k] <= '0;
`ifdef PERF_OVERFLOW_FLAGS_EN
        ovf <= '0;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start_i)
              state <= ST_RUN;
          end

          ST_RUN: begin
            if (!bus.start_i) begin
              state <= ST_IDLE;
            end else begin
              cycle_cnt <= bump(cycle_cnt);
              for (int k = 0; k < NUM_CH; k++) begin
                if (bus.event_i[k]) begin
                  cnt[k] <= bump(cnt[k]);
`ifdef PERF_OVERFLOW_FLAGS_EN
                  if (ovf_hit(cnt[k]))
                    ovf[k] <= 1'b1;
`endif
                end
              end
              if (LIMIT_ON && (bump(cycle_cnt) == LIMIT_VAL)) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end
          end

          ST_DONE: begin
            state <= ST_DONE;
          end

          default: begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rd_data_o    = rd_data;
  assign bus.cycle_o      = cycle_cnt;
  assign bus.state_o      = state;
  assign bus.done_o       = done;
  assign bus.snap_valid_o = snap_valid;
`ifdef PERF_OVERFLOW_FLAGS_EN
  assign bus.ovf_o        = ovf;
`endif

endmodule
